// File: rtl/i2cm_byte_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2cm_byte_ctrl
// Brief    : I2C master byte controller. It sequences optional (repeated)
//            START, 8 MSB-first data bits, the ACK slot and an optional STOP.
//            Each bus phase lasts CLK_DIV clocks. Between transfers without
//            STOP, SCL stays held low.
// Options  : I2CM_CLK_STRETCH_EN - freeze phase timing while a slave holds
//            SCL low after the master released it.
// Revision : 1.0 - initial release
// ============================================================================
module i2cm_byte_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic i_start,
    input  logic i_stop,
    input  logic i_data_ser,
    input  logic i_sda,
    input  logic i_scl,
    output logic o_shift_en,
    output logic o_store_en,
    output logic o_scl_oe,
    output logic o_sda_oe,
    output logic o_busy,
    output logic o_done,
    output logic o_nack
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_ACK   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    localparam logic [7:0] c_cnt_last = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] ph_q, ph_d;
    logic [2:0] bit_q, bit_d;
    logic       scl_oe_q, scl_oe_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       nack_q, nack_d;
    logic       stop_q, stop_d;

    logic       w_stall;
    logic       w_phase_end;
    logic       w_accept;

`ifdef I2CM_CLK_STRETCH_EN
    // A slave holding SCL low after we released it stretches the current phase.
    assign w_stall = (state_q != S_IDLE) && !scl_oe_q && !i_scl;
`else
    assign w_stall = 1'b0;
    logic unused_scl;
    assign unused_scl = i_scl;
`endif

    assign w_phase_end = (state_q != S_IDLE) && (cnt_q == c_cnt_last) && !w_stall;
    assign w_accept    = (state_q == S_IDLE) && i_req;

    // Load strobe is gated by reset so the shifter is never loaded while in reset.
    assign o_store_en  = ~(rst_n & w_accept);
    // Shift after bits 0..6 only; the 8th bit's shift would expose nothing useful.
    assign o_shift_en  = (state_q == S_DATA) && (ph_q == 2'd3) && w_phase_end &&
                         (bit_q != 3'd7);

    assign o_scl_oe = scl_oe_q;
    assign o_sda_oe = sda_oe_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_nack   = nack_q;

    // Next-state logic: phase timing plus line levels set at phase boundaries.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ph_d     = ph_q;
        bit_d    = bit_q;
        scl_oe_d = scl_oe_q;
        sda_oe_d = sda_oe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        nack_d   = nack_q;
        stop_d   = stop_q;

        if ((state_q != S_IDLE) && !w_stall) begin
            if (w_phase_end) begin
                cnt_d = 8'd0;
                ph_d  = ph_q + 2'd1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (i_req) begin
                    busy_d = 1'b1;
                    nack_d = 1'b0;
                    stop_d = i_stop;
                    cnt_d  = 8'd0;
                    ph_d   = 2'd0;
                    bit_d  = 3'd0;
                    if (i_start) begin
                        state_d  = S_START;
                        sda_oe_d = 1'b0;
                    end else begin
                        state_d  = S_DATA;
                        scl_oe_d = 1'b1;
                    end
                end
            end
            S_START: begin
                if (w_phase_end) begin
                    case (ph_q)
                        2'd0:    scl_oe_d = 1'b0;
                        2'd1:    sda_oe_d = 1'b1;
                        2'd2:    scl_oe_d = 1'b1;
                        default: state_d  = S_DATA;
                    endcase
                end
            end
            S_DATA: begin
                // The shifter settles one cycle after the load/shift edge, so
                // the bit is taken in the first cycle of Q0 while SCL is low.
                if ((ph_q == 2'd0) && (cnt_q == 8'd0)) begin
                    sda_oe_d = ~i_data_ser;
                end
                if (w_phase_end) begin
                    if (ph_q == 2'd1) begin
                        scl_oe_d = 1'b0;
                    end else if (ph_q == 2'd3) begin
                        scl_oe_d = 1'b1;
                        if (bit_q == 3'd7) begin
                            state_d  = S_ACK;
                            sda_oe_d = 1'b0;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
            end
            S_ACK: begin
                if (w_phase_end) begin
                    case (ph_q)
                        2'd1: scl_oe_d = 1'b0;
                        2'd2: nack_d   = i_sda;
                        2'd3: begin
                            scl_oe_d = 1'b1;
                            if (stop_q) begin
                                state_d  = S_STOP;
                                sda_oe_d = 1'b1;
                            end else begin
                                state_d  = S_IDLE;
                                sda_oe_d = 1'b0;
                                done_d   = 1'b1;
                                busy_d   = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_STOP: begin
                if (w_phase_end) begin
                    case (ph_q)
                        2'd0: scl_oe_d = 1'b0;
                        2'd1: sda_oe_d = 1'b0;
                        2'd3: begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts and releases both lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            ph_q     <= 2'd0;
            bit_q    <= 3'd0;
            scl_oe_q <= 1'b0;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            nack_q   <= 1'b0;
            stop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ph_q     <= ph_d;
            bit_q    <= bit_d;
            scl_oe_q <= scl_oe_d;
            sda_oe_q <= sda_oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            nack_q   <= nack_d;
            stop_q   <= stop_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2cm_byte_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2cm_byte_ctrl
// Brief    : Self-checking bench for i2cm_byte_ctrl (CLK_DIV=4). A byte
//            shifter and slave bus model surround the DUT; expected transfer
//            results are queued at request time and compared at o_done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2cm_byte_ctrl;

    localparam int CLK_DIV = 4;
`ifdef I2CM_CLK_STRETCH_EN
    localparam int STRETCH_EXTRA = 10;
`else
    localparam int STRETCH_EXTRA = 0;
`endif

    logic clk, rst_n;
    logic i_req, i_start, i_stop, i_data_ser, i_sda, i_scl;
    logic o_shift_en, o_store_en, o_scl_oe, o_sda_oe, o_busy, o_done, o_nack;

    logic [7:0] ld_data;
    logic [7:0] sr;
    logic       sda_slave;
    logic       scl_hold;

    i2cm_byte_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .i_data_ser (i_data_ser),
        .i_sda      (i_sda),
        .i_scl      (i_scl),
        .o_shift_en (o_shift_en),
        .o_store_en (o_store_en),
        .o_scl_oe   (o_scl_oe),
        .o_sda_oe   (o_sda_oe),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_nack     (o_nack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte shifter: parallel load when store_en=0, shift left on shift_en.
    initial sr = 8'h00;
    always @(posedge clk) begin
        if (!o_store_en)     sr <= ld_data;
        else if (o_shift_en) sr <= {sr[6:0], 1'b0};
    end
    assign i_data_ser = sr[7];

    // Open-drain bus: the slave may pull SDA or stretch SCL.
    assign i_sda = o_sda_oe ? 1'b0 : sda_slave;
    assign i_scl = o_scl_oe ? 1'b0 : ~scl_hold;

    typedef struct {
        bit         start;
        bit         stop;
        logic [7:0] data;
        bit         ack;
        int         mode;      // 0 plain, 1 SCL stretch in bit 2 Q2, 2 i_req pulse at cycle 50
        int         exp_cyc;
        bit         exp_nack;
        bit         exp_idle_scl;
    } vec_t;

    typedef struct {
        int         cyc;
        bit         nack;
        logic [7:0] data;
        bit         stop;
        int         starts;
        int         stops;
        bit         idle_scl;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    exp_t m_e;

    int checks = 0;
    int passed = 0;
    bit last_nack = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: cycle count from accept, bus events, and scoreboard compare at o_done.
    int         cyc = 0;
    int         shifts = 0;
    int         starts = 0;
    int         stops = 0;
    int         done_total = 0;
    logic [10:0] sh = '0;
    logic       prev_scl = 1'b0;
    logic       prev_sda = 1'b0;

    always @(negedge clk) begin
        if (rst_n && !o_store_en) begin
            cyc = 0; shifts = 0; starts = 0; stops = 0; sh = '0;
        end else begin
            cyc++;
        end
        if (o_shift_en) shifts++;
        if (prev_scl && !o_scl_oe) sh = {sh[9:0], ~o_sda_oe};
        if (!prev_scl && !o_scl_oe) begin
            if (!prev_sda && o_sda_oe) starts++;
            if (prev_sda && !o_sda_oe) stops++;
        end
        if (o_done) begin
            done_total++;
            if (sb.size() == 0) begin
                fail_now("spurious_done");
            end else begin
                m_e = sb.pop_front();
                check("done_cycle", cyc, m_e.cyc);
                check("nack", o_nack, m_e.nack);
                check("data_on_sda", m_e.stop ? int'(sh[9:2]) : int'(sh[8:1]), m_e.data);
                check("shift_pulses", shifts, 7);
                check("start_conds", starts, m_e.starts);
                check("stop_conds", stops, m_e.stops);
                check("busy_at_done", o_busy, 0);
                check("idle_scl_oe", o_scl_oe, m_e.idle_scl);
                check("idle_sda_oe", o_sda_oe, 0);
            end
        end
        prev_scl = o_scl_oe;
        prev_sda = o_sda_oe;
    end

    task automatic check_reset_vals();
        check("rst_scl_oe", o_scl_oe, 0);
        check("rst_sda_oe", o_sda_oe, 0);
        check("rst_shift_en", o_shift_en, 0);
        check("rst_store_en", o_store_en, 1);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_nack", o_nack, 0);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   d0;
        @(posedge clk); #1;
        check("nack_hold", o_nack, last_nack);
        check("idle_busy", o_busy, 0);
        ld_data   = v.data;
        sda_slave = v.ack;
        i_req     = 1'b1;
        i_start   = v.start;
        i_stop    = v.stop;
        e.cyc      = v.exp_cyc;
        e.nack     = v.exp_nack;
        e.data     = v.data;
        e.stop     = v.stop;
        e.starts   = v.start ? 1 : 0;
        e.stops    = v.stop ? 1 : 0;
        e.idle_scl = v.exp_idle_scl;
        sb.push_back(e);
        d0 = done_total;
        @(posedge clk); #1;
        i_req = 1'b0; i_start = 1'b0; i_stop = 1'b0;
        check("busy_after_accept", o_busy, 1);
        if (v.mode == 1) begin
            repeat (41) @(posedge clk);
            #1 scl_hold = 1'b1;
            repeat (10) @(posedge clk);
            #1 scl_hold = 1'b0;
        end else if (v.mode == 2) begin
            repeat (49) @(posedge clk);
            #1 i_req = 1'b1; i_start = 1'b1; i_stop = 1'b1;
            @(posedge clk);
            #1 i_req = 1'b0; i_start = 1'b0; i_stop = 1'b0;
        end
        for (int i = 0; i < 1000 && done_total == d0; i++) @(posedge clk);
        if (done_total == d0) begin
            fail_now("done_timeout");
            sb.delete();
        end
        last_nack = v.exp_nack;
        if (v.mode == 2) begin
            repeat (60) @(posedge clk);
            check("single_done", done_total - d0, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        //        start stop data   ack mode cycles              nack idle_scl
        vecs[0] = '{1'b1, 1'b1, 8'hA5, 1'b0, 0, 177,                1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 8'h3C, 1'b1, 0, 145,                1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 8'h5A, 1'b0, 0, 161,                1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 8'hFF, 1'b1, 0, 161,                1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 8'h00, 1'b0, 2, 177,                1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 8'h81, 1'b0, 1, 145 + STRETCH_EXTRA, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 8'hC3, 1'b1, 0, 177,                1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 8'h96, 1'b1, 0, 161,                1'b1, 1'b0};

        rst_n = 1'b0; i_req = 1'b1; i_start = 1'b0; i_stop = 1'b0;
        ld_data = 8'h00; sda_slave = 1'b1; scl_hold = 1'b0;
        #3;
        check_reset_vals();
        repeat (2) @(posedge clk);
        #1 i_req = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 7; k++) run_vec(vecs[k]);

        // Abort mid-byte (DATA bit 3) with a reset asserted between clock edges.
        @(posedge clk); #1;
        ld_data = 8'h96; sda_slave = 1'b0;
        i_req = 1'b1; i_start = 1'b0; i_stop = 1'b1;
        @(posedge clk); #1;
        i_req = 1'b0; i_stop = 1'b0;
        repeat (53) @(posedge clk);
        #3;
        check("busy_mid_byte", o_busy, 1);
        rst_n = 1'b0;
        i_req = 1'b1;
        #1;
        check_reset_vals();
        last_nack = 1'b0;
        repeat (2) @(posedge clk);
        #1 i_req = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("no_done_on_abort", done_total, 7);

        run_vec(vecs[7]);

        repeat (20) @(posedge clk);
        check("done_total", done_total, 8);
        check("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
